// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO stream reader.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    localparam int FIFO_RD_LATENCY = 1;
    localparam int SKID_DEPTH      = 2;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry skid buffer: head drives the stream, spare absorbs the in-flight word.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_valid,
    output occ_state_t            o_occ
);

    occ_state_t            r_occ;
    occ_state_t            w_occ_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_spare;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_spare_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ   <= OCC_EMPTY;
            r_head  <= '0;
            r_spare <= '0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_head  <= w_head_nxt;
            r_spare <= w_spare_nxt;
        end
    end

    // Occupancy transitions; the credit logic upstream keeps push into a full buffer unreachable.
    always_comb begin
        w_occ_nxt   = r_occ;
        w_head_nxt  = r_head;
        w_spare_nxt = r_spare;
        case (r_occ)
            OCC_EMPTY: begin
                if (i_push) begin
                    w_head_nxt = i_push_data;
                    w_occ_nxt  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({i_push, i_pop})
                    2'b11: w_head_nxt = i_push_data;
                    2'b10: begin
                        w_spare_nxt = i_push_data;
                        w_occ_nxt   = OCC_TWO;
                    end
                    2'b01: w_occ_nxt = OCC_EMPTY;
                    default: ;
                endcase
            end
            OCC_TWO: begin
                if (i_pop) begin
                    w_head_nxt = r_spare;
                    if (i_push) begin
                        w_spare_nxt = i_push_data;
                    end else begin
                        w_occ_nxt = OCC_ONE;
                    end
                end
            end
            default: w_occ_nxt = OCC_EMPTY;
        endcase
    end

    assign o_head_data = r_head;
    assign o_valid     = (r_occ != OCC_EMPTY);
    assign o_occ       = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side consumer: pops a registered-output FIFO and re-emits words as a valid/ready stream.
// Optional accepted-word counter on rd_count when FIFO_RD_CNT_EN is defined.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_RD_CNT_EN
   ,output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

    logic [FIFO_RD_LATENCY-1:0] r_inflight;
    logic                       w_valid;
    logic                       w_pop;
    logic [2:0]                 w_credit;
    occ_state_t                 w_occ;
    logic [DATA_WIDTH-1:0]      w_head;

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight[0]),
        .i_push_data (fifo_dout),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_valid     (w_valid),
        .o_occ       (w_occ)
    );

    // Request only when the word would still fit once everything in flight has landed.
    assign w_pop      = w_valid && m_ready;
    assign w_credit   = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
    assign fifo_rd_en = !rst && !fifo_empty && (w_credit < 3'(SKID_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= FIFO_RD_LATENCY'(fifo_rd_en);
        end
    end

    assign m_valid = w_valid;
    assign m_data  = w_head;

`ifdef FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0] r_rd_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_count <= '0;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + CNT_WIDTH'(1);
        end
    end

    assign rd_count = r_rd_count;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, ordered scoreboard, directed tables and random traffic.
module tb_fifo_stream_reader;

    localparam int DW = 8;
`ifdef FIFO_RD_CNT_EN
    localparam int CW = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
`ifdef FIFO_RD_CNT_EN
    logic [CW-1:0] rd_count;
`endif

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH (DW)
`ifdef FIFO_RD_CNT_EN
       ,.CNT_WIDTH  (CW)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
`ifdef FIFO_RD_CNT_EN
       ,.rd_count   (rd_count)
`endif
    );

    typedef struct {
        logic          ready;
        logic          exp_rd;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t          vecs [6];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    int            n_taken = 0;
    int            n_acc   = 0;
    int            n_rd    = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: check at mid-low phase, advance through the edge, model the FIFO's registered dout.
    task automatic step();
        logic rd;
        #1;
        if (fifo_empty) check("rd_en_while_empty", 32'(fifo_rd_en), 32'd0);
        if (prev_stall) begin
            check("stall_valid_held", 32'(m_valid), 32'd1);
            check("stall_data_held", 32'(m_data), 32'(prev_data));
        end
        check("skid_bound", 32'((n_taken - n_acc) <= 2), 32'd1);
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            n_acc++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        rd         = fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) begin
            fifo_dout = fifo_q.pop_front();
            n_taken++;
        end
        if (rd) n_rd++;
        fifo_empty = (fifo_q.size() == 0);
`ifdef FIFO_RD_CNT_EN
        check("rd_count_track", 32'(rd_count), 32'(n_acc % (1 << CW)));
`endif
        @(negedge clk);
    endtask

    task automatic drain(input int budget, input string name);
        int cyc = 0;
        m_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < budget) begin
            step();
            cyc++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int acc0;
        vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 8'hA1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 8'hB2};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 8'hC3};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00};

        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        m_ready    = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_m_valid", 32'(m_valid), 32'd0);
        check("reset_m_data", 32'(m_data), 32'd0);
        fifo_empty = 1'b0;
        #1;
        check("reset_rd_en_gated", 32'(fifo_rd_en), 32'd0);
        fifo_empty = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Idle with an empty FIFO.
        for (int i = 0; i < 20; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            #1;
            check("idle_rd_en", 32'(fifo_rd_en), 32'd0);
            check("idle_m_valid", 32'(m_valid), 32'd0);
            step();
        end

        // Three words at full rate: latency and back-to-back output.
        push_word(8'hA1);
        push_word(8'hB2);
        push_word(8'hC3);
        for (int i = 0; i < 6; i++) begin
            m_ready = vecs[i].ready;
            #1;
            check("vec_rd_en", 32'(fifo_rd_en), 32'(vecs[i].exp_rd));
            check("vec_m_valid", 32'(m_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check("vec_m_data", 32'(m_data), 32'(vecs[i].exp_data));
            step();
        end

        // Sink stalled: exactly two pops, then hold the first word.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
        rd0 = n_rd;
        for (int i = 0; i < 10; i++) step();
        check("stall_rd_pulses", 32'(n_rd - rd0), 32'd2);
        check("stall_head_valid", 32'(m_valid), 32'd1);
        check("stall_head_data", 32'(m_data), 32'h10);
        check("stall_rd_en_low", 32'(fifo_rd_en), 32'd0);
        m_ready = 1'b1;
        acc0 = n_acc;
        for (int i = 0; i < 20 && (n_acc - acc0) < 8; i++) begin
            #1;
            check("resume_no_gap", 32'(m_valid), 32'd1);
            step();
        end
        check("resume_count", 32'(n_acc - acc0), 32'd8);

        // Alternating ready.
        for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i * 3));
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            m_ready = (i % 2 == 0);
            step();
        end
        check("toggle_drained", 32'(exp_q.size()), 32'd0);

        // Reset while the buffer is full.
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'h80 + 8'(i));
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_full", 32'(m_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_m_data", 32'(m_data), 32'd0);
        check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        prev_stall = 1'b0;
        n_taken    = 0;
        n_acc      = 0;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("post_reset_idle", 32'(m_valid), 32'd0);
        for (int i = 0; i < 18; i++) push_word(8'($urandom));
        drain(80, "post_reset_drain");
        check("post_reset_accepted", 32'(n_acc), 32'd18);
`ifdef FIFO_RD_CNT_EN
        check("rd_count_wrap", 32'(rd_count), 32'd2);
`endif

        // Random traffic against the ordered scoreboard.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) push_word(8'($urandom));
            m_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain(100, "random_drain");
        for (int i = 0; i < 3; i++) step();
        check("final_idle", 32'(m_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
